ladybird_debounce: RTL and testbench
====================================

// Module: ladybird_debounce
// PURPOSE
//  Per-channel synchroniser and debouncer for raw board switches/buttons. Sits directly
//  upstream of the GPIO peripheral and drives its GPIO_I input with clean, glitch-free
//  levels. Also gives one-cycle rise/fall pulses for logic that wants edge events.
//  Channels are fully independent; nothing is shared between channels.
// PARAMETERS
//  WIDTH            8       number of channels (= GPIO E_WIDTH*N_INPUT)
//  DEBOUNCE_CYCLES  100000  consecutive stable clk cycles needed to accept a change (>=1; 1 ms @ 100 MHz)
//  CNT_WIDTH        17      counter width; must satisfy 2**CNT_WIDTH > DEBOUNCE_CYCLES-1
// PORTS
//  clk      in   1      system clock
//  nrst     in   1      reset, synchronous, active-low
//  raw_i    in   WIDTH  asynchronous pad inputs (switches, buttons)
//  level_o  out  WIDTH  debounced level; connects to GPIO_I
//  rise_o   out  WIDTH  1-cycle pulse when level_o goes 0->1
//  fall_o   out  WIDTH  1-cycle pulse when level_o goes 1->0
// BEHAVIOUR
//  - Reset (nrst=0 at posedge clk): sync stages=0, counters=0, FSM=LOW; level_o, rise_o and fall_o = 0.
//  - Synchroniser: 2-flop chain per channel, raw_i -> s1 -> s2. Only s2 feeds the FSM.
//  - Per-channel FSM states: LOW, WAIT_HIGH, HIGH, WAIT_LOW. level_o=1 in HIGH and WAIT_LOW.
//    LOW:       s2=1 -> WAIT_HIGH, cnt<=1; else stay in LOW, cnt<=0.
//    WAIT_HIGH: s2=0 -> LOW, cnt<=0 (bounce rejected);
//               s2=1 and cnt==DEBOUNCE_CYCLES-1 -> HIGH, cnt<=0, rise_o=1 next cycle;
//               s2=1 otherwise -> cnt<=cnt+1.
//    HIGH / WAIT_LOW: mirror of LOW / WAIT_HIGH with s2 inverted; the accepting transition pulses fall_o.
//  - DEBOUNCE_CYCLES==1: LOW goes straight to HIGH on the first s2=1 cycle, with no WAIT state
//    (the same applies for HIGH->LOW).
//  - Timing: if s2 first shows the new value at edge t and holds, level_o changes at edge
//    t+DEBOUNCE_CYCLES. raw_i to level_o is 2+DEBOUNCE_CYCLES cycles.
//  - rise_o/fall_o are registered. They assert on the same edge that level_o changes, for
//    exactly one cycle. They are never both high, and never high in two consecutive cycles.
//  - Any s2 reversal during a WAIT state restarts the count from scratch; a partial count is never kept.
//  - The counter never wraps, because it is cleared on acceptance and the parameter constraint bounds it.
//  - Reset mid-count or mid-pulse: everything returns to its reset value on the next edge, and
//    no pulse is emitted. An input held high through reset is reported as a fresh rise
//    2+DEBOUNCE_CYCLES cycles after reset is released.
//  - Combinational input-to-output paths: none.
// TESTING (bench uses DEBOUNCE_CYCLES=4, WIDTH=8)
//  1 reset: nrst=0 for 3 cycles with raw_i=8'hFF -> level_o/rise_o/fall_o all 0 during reset;
//    after release, level_o=8'hFF exactly 6 cycles later and rise_o=8'hFF for 1 cycle.
//  2 clean press: raw_i[0] 0->1 and held -> level_o[0] rises 6 cycles later, rise_o[0] one pulse,
//    other bits unchanged.
//  3 bounce: raw_i[1] pattern 1,0,1,1,0,1,1,1,1,... -> no level change until 4 consecutive
//    synchronised 1s; level_o[1] rises once, exactly one rise_o[1] pulse.
//  4 glitch rejection: raw_i[2] high for 3 cycles, then low -> level_o[2] stays 0, no pulses.
//  5 release and independence: bit 3 released and bit 4 pressed in the same cycle ->
//    fall_o[3] and rise_o[4] pulse on the same edge, 6 cycles later.
//  6 reset mid-count: nrst=0 while bit 5 is in WAIT_HIGH with cnt=2 -> cnt cleared, no rise
//    pulse; after release the full 6-cycle latency applies again.

Source files
------------

// File: rtl/ladybird_debounce.sv
// Per-channel two-flop synchroniser and debouncer for raw switch/button pads.
// Produces clean levels for GPIO_I and one-cycle rise/fall event pulses.
module ladybird_debounce #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned CNT_WIDTH       = 17
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    typedef enum logic [1:0] {
        LOW       = 2'b00,
        WAIT_HIGH = 2'b01,
        HIGH      = 2'b10,
        WAIT_LOW  = 2'b11
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam bit                   NO_WAIT  = (DEBOUNCE_CYCLES == 1);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    // Metastability guard: only s2_q is ever looked at by the FSMs.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        state_e               state_q;
        logic [CNT_WIDTH-1:0] cnt_q;
        logic                 rise_q;
        logic                 fall_q;

        // A reversal of s2 in a WAIT state drops the partial count entirely.
        always_ff @(posedge clk) begin
            if (!nrst) begin
                state_q <= LOW;
                cnt_q   <= '0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                case (state_q)
                    LOW: begin
                        if (s2_q[g] && NO_WAIT) begin
                            state_q <= HIGH;
                            cnt_q   <= '0;
                            rise_q  <= 1'b1;
                        end else if (s2_q[g]) begin
                            state_q <= WAIT_HIGH;
                            cnt_q   <= CNT_ONE;
                        end else begin
                            cnt_q   <= '0;
                        end
                    end
                    WAIT_HIGH: begin
                        if (!s2_q[g]) begin
                            state_q <= LOW;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= HIGH;
                            cnt_q   <= '0;
                            rise_q  <= 1'b1;
                        end else begin
                            cnt_q   <= cnt_q + CNT_ONE;
                        end
                    end
                    HIGH: begin
                        if (!s2_q[g] && NO_WAIT) begin
                            state_q <= LOW;
                            cnt_q   <= '0;
                            fall_q  <= 1'b1;
                        end else if (!s2_q[g]) begin
                            state_q <= WAIT_LOW;
                            cnt_q   <= CNT_ONE;
                        end else begin
                            cnt_q   <= '0;
                        end
                    end
                    WAIT_LOW: begin
                        if (s2_q[g]) begin
                            state_q <= HIGH;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= LOW;
                            cnt_q   <= '0;
                            fall_q  <= 1'b1;
                        end else begin
                            cnt_q   <= cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= LOW;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        assign level_o[g] = (state_q == HIGH) || (state_q == WAIT_LOW);
        assign rise_o[g]  = rise_q;
        assign fall_o[g]  = fall_q;
    end

endmodule

// File: tb/tb_ladybird_debounce.sv
// Directed bench for ladybird_debounce with a run-length behavioural model
// compared every cycle, plus literal checks at the key edges.
module tb_ladybird_debounce;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

    logic         clk = 1'b0;
    logic         nrst;
    logic [W-1:0] raw_i;
    logic [W-1:0] level_o;
    logic [W-1:0] rise_o;
    logic [W-1:0] fall_o;

    int total = 0;
    int bad   = 0;

    ladybird_debounce #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D),
        .CNT_WIDTH      (3)
    ) dut (
        .clk    (clk),
        .nrst   (nrst),
        .raw_i  (raw_i),
        .level_o(level_o),
        .rise_o (rise_o),
        .fall_o (fall_o)
    );

    always #5 clk = ~clk;

    // Model: two-sample delay, then a level flips once D consecutive
    // synchronised samples disagree with it.
    logic [W-1:0] m_s1 = '0;
    logic [W-1:0] m_s2 = '0;
    logic [W-1:0] m_level = '0;
    logic [W-1:0] m_rise = '0;
    logic [W-1:0] m_fall = '0;
    int           m_run [W];

    always @(posedge clk) begin
        if (!nrst) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < W; i++) begin
                if (m_s2[i] != m_level[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == D) begin
                        m_level[i] = ~m_level[i];
                        m_run[i]   = 0;
                        if (m_level[i]) m_rise[i] = 1'b1;
                        else            m_fall[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = raw_i;
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_level", level_o, m_level);
        chk("model_rise", rise_o, m_rise);
        chk("model_fall", fall_o, m_fall);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int           rcnt;
    logic [19:0]  pat;

    initial begin
        for (int i = 0; i < W; i++) m_run[i] = 0;
        nrst  = 1'b0;
        raw_i = 8'hFF;

        // 1: reset with inputs high, then fresh rise after release
        repeat (3) tick();
        chk("rst_level", level_o, 8'h00);
        chk("rst_rise", rise_o, 8'h00);
        chk("rst_fall", fall_o, 8'h00);
        nrst = 1'b1;
        repeat (5) tick();
        chk("t1_level_early", level_o, 8'h00);
        tick();
        chk("t1_level", level_o, 8'hFF);
        chk("t1_rise", rise_o, 8'hFF);
        tick();
        chk("t1_rise_gone", rise_o, 8'h00);

        raw_i = 8'h00;
        repeat (8) tick();
        chk("all_low", level_o, 8'h00);

        // 2: clean press on bit 0
        raw_i = 8'h01;
        repeat (5) tick();
        chk("t2_level_early", level_o, 8'h00);
        tick();
        chk("t2_level", level_o, 8'h01);
        chk("t2_rise", rise_o, 8'h01);
        tick();
        chk("t2_rise_gone", rise_o, 8'h00);

        // 3: bouncing press on bit 1; last run of ones starts at position 5
        pat  = 20'hFFFED;
        rcnt = 0;
        for (int i = 0; i < 20; i++) begin
            raw_i[1] = pat[i];
            tick();
            rcnt += int'(rise_o[1]);
            if (i + 1 == 10) chk("t3_level_early", level_o, 8'h01);
            if (i + 1 == 11) begin
                chk("t3_level", level_o, 8'h03);
                chk("t3_rise", rise_o, 8'h02);
            end
        end
        chk("t3_rise_count", 8'(rcnt), 8'd1);

        // 4: three-cycle glitch on bit 2
        rcnt = 0;
        raw_i[2] = 1'b1;
        repeat (3) begin tick(); rcnt += int'(rise_o[2]); end
        raw_i[2] = 1'b0;
        repeat (10) begin tick(); rcnt += int'(rise_o[2]); end
        chk("t4_level", level_o, 8'h03);
        chk("t4_rise_count", 8'(rcnt), 8'd0);

        // 5: simultaneous release of bit 3 and press of bit 4
        raw_i[3] = 1'b1;
        repeat (8) tick();
        chk("t5_pre_level", level_o, 8'h0B);
        raw_i[3] = 1'b0;
        raw_i[4] = 1'b1;
        repeat (5) tick();
        chk("t5_rise_early", rise_o, 8'h00);
        chk("t5_fall_early", fall_o, 8'h00);
        tick();
        chk("t5_fall", fall_o, 8'h08);
        chk("t5_rise", rise_o, 8'h10);
        chk("t5_level", level_o, 8'h13);

        // 6: reset while bit 5 is two counts into its wait
        raw_i[5] = 1'b1;
        repeat (4) tick();
        nrst = 1'b0;
        tick();
        chk("t6_rst_level", level_o, 8'h00);
        chk("t6_rst_rise", rise_o, 8'h00);
        tick();
        nrst = 1'b1;
        repeat (5) tick();
        chk("t6_level_early", level_o, 8'h00);
        tick();
        chk("t6_level", level_o, 8'h33);
        chk("t6_rise", rise_o, 8'h33);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
